display_term_ctrl: RTL
======================

Name: display_term_ctrl

Overview:
- Write-side sequencer for the 40x24 Apple-1 style text display RAM (2048 x 6-bit, 11-bit address).
- Accepts a stream of 7-bit ASCII characters over a valid/ready handshake.
- Translates each character to the 6-bit glyph code, writes it at the cursor and advances the cursor.
- Handles CR, auto-wrap, hardware scroll (rotating top-row pointer) and full-screen clear; exports the top-row pointer and cursor address to the video scan logic.

Parameters:
- COLS, 40, characters per row.
- ROWS, 24, rows per screen.
- ADDR_W, 11, display RAM address width.
- DATA_W, 6, display RAM data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- char_in  in  7  ASCII character.
- char_valid  in  1  char_in valid.
- char_ready  out  1  controller can accept a character this cycle.
- clear_req  in  1  single-cycle pulse requesting a full-screen clear.
- w_en  out  1  display RAM write strobe.
- w_addr  out  ADDR_W  display RAM write address.
- w_data  out  DATA_W  display RAM write data.
- top_row  out  5  physical row shown at the top of the screen (0..ROWS-1).
- cursor_addr  out  ADDR_W  physical RAM address of the cursor cell.
- busy  out  1  a clear or line-clear sequence is in progress.

Behaviour:
- Physical address = phys_row*COLS + col. Multiply is implemented as (r<<5)+(r<<3) for COLS=40. Maximum address is 959; addresses 960..2047 are never written.
- Glyph map: 0x20-0x5F -> char[5:0]; 0x60-0x7F -> (char-0x20)[5:0] (upper-case fold); blank = 6'h20.
- Character classes:
  - CR (0x0D) is the newline code.
  - All other codes <0x20 are accepted and discarded; no write, no cursor move.
- All outputs are registered.
- Reset values: w_en=0, w_addr=0, w_data=6'h20, top_row=0, cursor_addr=0, char_ready=0, busy=1. State becomes CLR_SCREEN with counter=0.
- Handshake:
  - A transfer occurs when char_valid && char_ready.
  - char_ready = (state==IDLE) && !clear_pend.
  - char_in is sampled only on a transfer.
- States:
  - CLR_SCREEN: one write per cycle of 6'h20 to addresses 0..ROWS*COLS-1 (960 cycles). Then top_row=0, cursor at physical row 0, col 0, clear_pend=0 -> IDLE.
  - IDLE, printable transfer: next cycle w_en=1, w_addr=cursor_addr, w_data=glyph.
    - If col<COLS-1: col+1, stay IDLE, ready stays high. One character per cycle sustained.
    - If col==COLS-1: perform the newline step -> CLR_LINE.
  - IDLE, CR transfer: newline step -> CLR_LINE. No glyph write.
  - Newline step:
    - col=0; phys_row=(phys_row+1) mod ROWS.
    - If the logical row (phys_row - top_row mod ROWS) was ROWS-1, also top_row=(top_row+1) mod ROWS.
  - CLR_LINE: COLS consecutive writes of 6'h20 to new_row*COLS+0..COLS-1, one per cycle.
    - The first clear write is in the cycle after the triggering write/transfer.
    - After the last write -> IDLE; char_ready is high the following cycle.
- w_en is low in IDLE when no transfer occurred in the previous cycle.
- cursor_addr updates in the same cycle as the cursor registers.
- clear_req:
  - In any state it sets clear_pend.
  - IDLE with clear_pend -> CLR_SCREEN next cycle.
  - In CLR_LINE, the line clear finishes first, then CLR_SCREEN.
  - If clear_req and char_valid arrive together in IDLE, the clear wins: char_ready is already low that cycle or drops the next cycle, and the character is not consumed.
  - clear_req during CLR_SCREEN is absorbed; no restart.
- Reset mid-sequence aborts immediately. No further writes of the old sequence occur; a fresh CLR_SCREEN starts.
- Wrap-around: phys_row and top_row wrap ROWS-1 -> 0; col never exceeds COLS-1.

Decomposition:
- Package display_term_pkg holds:
  - COLS, ROWS, CHAR_CR=7'h0D, GLYPH_BLANK=6'h20;
  - the state enum (CLR_SCREEN, IDLE, CLR_LINE);
  - the row_base function (row*COLS).
- One natural sub-module: display_char_map, a combinational ASCII->6-bit glyph map plus printable/CR/ignore classification. The FSM, counters and address generation stay in display_term_ctrl.

Test Plan:
- Reset, no other stimulus -> 960 consecutive w_en pulses, w_addr 0..959, w_data 6'h20, char_ready low throughout, high on the next cycle; top_row=0, cursor_addr=0.
- After init, send 'A' (0x41) then 'a' (0x61) back-to-back -> writes (addr 0, 6'h01), (addr 1, 6'h01) on consecutive cycles; cursor_addr=2.
- Send 0x07 (bell) -> accepted, no w_en, cursor_addr unchanged. Then CR at col 1 -> 40 writes of 6'h20 to 40..79; cursor_addr=40; char_ready low for 40 cycles.
- Send 40 printable chars from col 0 -> last glyph write at addr 39, then line clear at 40..79; cursor_addr=40.
- Scroll: 23 CRs after init, then a 24th CR -> top_row=1, clear writes to 0..39, cursor_addr=0. A 25th CR -> top_row=2, clear 40..79.
- clear_req asserted mid CLR_LINE (cycle 10) with char_valid held high -> line clear completes all 40 writes, then a 960-write screen clear; char_ready stays low until its end; the pending character is accepted afterwards at addr 0.

Source files
------------

// File: rtl/display_term_pkg.sv
// Shared geometry, character constants, FSM state type and row-to-address helper
// for the Apple-1 style 40x24 text display write sequencer.
package display_term_pkg;

  localparam int COLS   = 40;
  localparam int ROWS   = 24;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 6;

  localparam logic [6:0] CHAR_CR     = 7'h0D;
  localparam logic [5:0] GLYPH_BLANK = 6'h20;

  typedef enum logic [1:0] {
    CLR_SCREEN,
    IDLE,
    CLR_LINE
  } state_e;

  // COLS is 40, so row*COLS reduces to two shifts and an add.
  function automatic logic [10:0] row_base(input logic [4:0] row);
    logic [10:0] r;
    r = {6'd0, row};
    return (r << 5) + (r << 3);
  endfunction

endpackage

// File: rtl/display_char_map.sv
// Combinational ASCII -> 6-bit glyph map with printable / CR classification.
// Lower-case range 0x60-0x7F folds onto 0x40-0x5F; codes below 0x20 other than CR are ignored.
module display_char_map
  import display_term_pkg::*;
(
  input  logic [6:0] char_i,
  output logic [5:0] glyph_o,
  output logic       is_print_o,
  output logic       is_cr_o
);

  always_comb begin
    glyph_o    = (char_i[6:5] == 2'b11) ? (char_i[5:0] - 6'h20) : char_i[5:0];
    is_print_o = (char_i >= 7'h20);
    is_cr_o    = (char_i == CHAR_CR);
  end

endmodule

// File: rtl/display_term_ctrl.sv
// Write-side sequencer for the display RAM: glyph writes at the cursor, newline/wrap,
// rotating top-row scroll, per-line and full-screen clears. All outputs registered.
module display_term_ctrl
  import display_term_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              clear_req,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [4:0]        top_row,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  localparam logic [9:0] LAST_CELL = 10'(COLS * ROWS - 1);
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);

  state_e              state_q, state_d;
  logic [9:0]          cnt_q, cnt_d;
  logic [5:0]          col_q, col_d;
  logic [4:0]          row_q, row_d;
  logic [4:0]          top_q, top_d;
  logic                clear_pend_q, clear_pend_d;
  logic                w_en_q, w_en_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic [5:0] glyph;
  logic       is_print;
  logic       is_cr;
  logic       xfer;
  logic [4:0] nl_row;
  logic [4:0] nl_top;
  logic [5:0] logical_row;
  logic       nl_scroll;

  display_char_map u_char_map (
    .char_i     (char_in),
    .glyph_o    (glyph),
    .is_print_o (is_print),
    .is_cr_o    (is_cr)
  );

  // A simultaneous clear request beats the character, which stays unconsumed.
  assign xfer = char_valid && ready_q && !clear_req;

  assign nl_row      = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign nl_top      = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
  assign logical_row = (row_q >= top_q) ? ({1'b0, row_q} - {1'b0, top_q})
                                        : ({1'b0, row_q} + 6'(ROWS) - {1'b0, top_q});
  assign nl_scroll   = (logical_row == {1'b0, LAST_ROW});

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    row_d        = row_q;
    top_d        = top_q;
    clear_pend_d = clear_pend_q | clear_req;
    w_en_d       = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;

    case (state_q)
      CLR_SCREEN: begin
        clear_pend_d = 1'b0;
        w_en_d       = 1'b1;
        w_addr_d     = {1'b0, cnt_q};
        w_data_d     = GLYPH_BLANK;
        cnt_d        = cnt_q + 10'd1;
        if (cnt_q == LAST_CELL) begin
          state_d = IDLE;
          cnt_d   = 10'd0;
          col_d   = 6'd0;
          row_d   = 5'd0;
          top_d   = 5'd0;
        end
      end

      IDLE: begin
        if (clear_pend_d) begin
          state_d      = CLR_SCREEN;
          cnt_d        = 10'd0;
          clear_pend_d = 1'b0;
        end else if (xfer && is_print) begin
          w_en_d   = 1'b1;
          w_addr_d = cursor_q;
          w_data_d = glyph;
          if (col_q != LAST_COL) begin
            col_d = col_q + 6'd1;
          end else begin
            col_d   = 6'd0;
            row_d   = nl_row;
            top_d   = nl_scroll ? nl_top : top_q;
            state_d = CLR_LINE;
            cnt_d   = 10'd0;
          end
        end else if (xfer && is_cr) begin
          // CR has no glyph write, so the first blank goes out on the transfer edge.
          col_d    = 6'd0;
          row_d    = nl_row;
          top_d    = nl_scroll ? nl_top : top_q;
          state_d  = CLR_LINE;
          w_en_d   = 1'b1;
          w_addr_d = row_base(nl_row);
          w_data_d = GLYPH_BLANK;
          cnt_d    = 10'd1;
        end
      end

      CLR_LINE: begin
        w_en_d   = 1'b1;
        w_addr_d = row_base(row_q) + {5'd0, cnt_q[5:0]};
        w_data_d = GLYPH_BLANK;
        cnt_d    = cnt_q + 10'd1;
        if (cnt_q == {4'd0, LAST_COL}) begin
          cnt_d = 10'd0;
          if (clear_pend_d) begin
            state_d      = CLR_SCREEN;
            clear_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = CLR_SCREEN;
        cnt_d   = 10'd0;
      end
    endcase

    cursor_d = row_base(row_d) + {5'd0, col_d};
    // Ready and busy also cover the cycle in which the final clear write is still on the bus.
    ready_d  = (state_q == IDLE) && (state_d == IDLE) && !clear_pend_d;
    busy_d   = (state_q != IDLE) || (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLR_SCREEN;
      cnt_q        <= 10'd0;
      col_q        <= 6'd0;
      row_q        <= 5'd0;
      top_q        <= 5'd0;
      clear_pend_q <= 1'b0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= GLYPH_BLANK;
      cursor_q     <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      clear_pend_q <= clear_pend_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      cursor_q     <= cursor_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign char_ready  = ready_q;
  assign w_en        = w_en_q;
  assign w_addr      = w_addr_q;
  assign w_data      = w_data_q;
  assign top_row     = top_q;
  assign cursor_addr = cursor_q;
  assign busy        = busy_q;

endmodule
